// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the four-digit seven-segment scanner: active-low
// segment patterns (a..g, index 0 = a), anode constants and small helpers.
package seg_scan_ctrl_pkg;

    localparam int PRESC_W = 20;

    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // One-hot-low anode pattern for a slot index.
    function automatic logic [3:0] an_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic nibble_bad(input logic [3:0] n);
        return n > 4'd9;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_bcd_seg_decoder.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-BCD nibbles fall back to the "0" pattern.
module bcd_seg_decoder
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [0:6] seg
);

    always_comb begin
        seg = SEG_0;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_0;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner: prescaler, scan index,
// held digit register and registered anode/segment/frame outputs.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] digits,
    input  logic        load,
    input  logic        en,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [0:6]  seg,
    output logic        frame,
    output logic        bad_digit
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

    logic [PRESC_W-1:0] presc;
    logic [1:0]         idx;
    logic [1:0]         idx_next;
    logic [15:0]        held;
    logic [15:0]        eff;
    logic               tick;
    logic [3:0]         nib;
    logic [0:6]         dec_seg;
    logic               blank;
    logic               z3;
    logic               z32;
    logic               z321;
    logic               bad_next;

    assign tick     = (presc == PRESC_MAX);
    assign idx_next = idx + 2'd1;

    // A load landing on the tick edge must already be visible to that slot.
    assign eff = load ? digits : held;

    assign bad_next = nibble_bad(digits[15:12]) | nibble_bad(digits[11:8]) |
                      nibble_bad(digits[7:4])   | nibble_bad(digits[3:0]);

    always_comb begin
        nib = eff[3:0];
        case (idx_next)
            2'd0: nib = eff[3:0];
            2'd1: nib = eff[7:4];
            2'd2: nib = eff[11:8];
            2'd3: nib = eff[15:12];
            default: nib = eff[3:0];
        endcase
    end

    // A digit is a leading zero when it and every digit above it are zero.
    assign z3   = (eff[15:12] == 4'd0);
    assign z32  = z3  && (eff[11:8] == 4'd0);
    assign z321 = z32 && (eff[7:4] == 4'd0);

    always_comb begin
        blank = 1'b0;
        if (blank_lz) begin
            case (idx_next)
                2'd3:    blank = z3;
                2'd2:    blank = z32;
                2'd1:    blank = z321;
                default: blank = 1'b0;
            endcase
        end
    end

    bcd_seg_decoder u_dec (
        .bcd (nib),
        .seg (dec_seg)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (tick) begin
            presc <= '0;
            idx   <= idx_next;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held      <= 16'h0000;
            bad_digit <= 1'b0;
        end else if (load) begin
            held      <= digits;
            bad_digit <= bad_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an    <= AN_OFF;
            seg   <= SEG_BLANK;
            frame <= 1'b0;
        end else begin
            frame <= tick && (idx == 2'd3);
            if (tick) begin
                if (en) begin
                    an  <= an_sel(idx_next);
                    seg <= blank ? SEG_BLANK : dec_seg;
                end else begin
                    an  <= AN_OFF;
                    seg <= SEG_BLANK;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with REFRESH_DIV=4: one table row per
// scan slot, then hand sequences for load-on-tick and mid-slot reset.
module tb_seg_scan_ctrl;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic        load = 1'b0;
    logic        en = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [0:6]  seg;
    logic        frame;
    logic        bad_digit;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic        ld;
        logic [15:0] dg;
        logic        en;
        logic        blz;
        logic [3:0]  an;
        logic [0:6]  seg;
        logic        fr;
        logic        bad;
    } vec_t;

    vec_t vecs [24];

    always #5 clk = ~clk;

    seg_scan_ctrl #(.REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .digits    (digits),
        .load      (load),
        .en        (en),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .frame     (frame),
        .bad_digit (bad_digit)
    );

    function automatic vec_t mk(input logic ld, input logic [15:0] dg, input logic e,
                                input logic b, input logic [3:0] a, input logic [0:6] s,
                                input logic f, input logic bd);
        vec_t v;
        v.ld = ld; v.dg = dg; v.en = e; v.blz = b;
        v.an = a; v.seg = s; v.fr = f; v.bad = bd;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Starts at a negedge with the prescaler about to count from 0; ends at
    // the negedge right after the slot's tick edge.
    task automatic run_slot(input vec_t v, input int k);
        load = v.ld; digits = v.dg; en = v.en; blank_lz = v.blz;
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        check($sformatf("slot%0d frame_low", k), 16'(frame), 16'(1'b0));
        check($sformatf("slot%0d bad", k), 16'(bad_digit), 16'(v.bad));
        repeat (RD - 1) @(posedge clk);
        @(negedge clk);
        check($sformatf("slot%0d an", k), 16'(an), 16'(v.an));
        check($sformatf("slot%0d seg", k), 16'(seg), 16'(v.seg));
        check($sformatf("slot%0d frame", k), 16'(frame), 16'(v.fr));
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 16'h1234, 1'b1, 1'b0, 4'b1101, 7'b0000110, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 4'b1011, 7'b0010010, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 4'b0111, 7'b1001111, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110, 7'b1001100, 1'b1, 1'b0);
        vecs[4]  = mk(1'b1, 16'h0070, 1'b1, 1'b1, 4'b1101, 7'b0001111, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 4'b1011, 7'b1111111, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 4'b0111, 7'b1111111, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 4'b1110, 7'b0000001, 1'b1, 1'b0);
        vecs[8]  = mk(1'b1, 16'h00A5, 1'b1, 1'b0, 4'b1101, 7'b0000001, 1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 4'b1011, 7'b0000001, 1'b0, 1'b1);
        vecs[10] = mk(1'b1, 16'h0005, 1'b1, 1'b0, 4'b0111, 7'b0000001, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110, 7'b0100100, 1'b1, 1'b0);
        for (int i = 12; i < 20; i++)
            vecs[i] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 4'b1111, 7'b1111111,
                         (i == 15 || i == 19) ? 1'b1 : 1'b0, 1'b0);
        vecs[20] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 4'b1101, 7'b0000001, 1'b0, 1'b0);
        vecs[21] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 4'b1011, 7'b1111111, 1'b0, 1'b0);
        vecs[22] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 4'b0111, 7'b1111111, 1'b0, 1'b0);
        vecs[23] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 4'b1110, 7'b0100100, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset an", 16'(an), 16'(4'b1111));
        check("reset seg", 16'(seg), 16'(7'b1111111));
        check("reset frame", 16'(frame), 16'(1'b0));
        check("reset bad", 16'(bad_digit), 16'(1'b0));

        reset_n = 1'b1;
        for (int i = 0; i < 24; i++) run_slot(vecs[i], i + 1);

        // Load asserted on the tick cycle itself: the new word drives slot 1.
        repeat (RD - 1) @(posedge clk);
        @(negedge clk);
        load = 1'b1; digits = 16'h9999;
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        check("loadtick an", 16'(an), 16'(4'b1101));
        check("loadtick seg", 16'(seg), 16'(7'b0000100));
        check("loadtick bad", 16'(bad_digit), 16'(1'b0));

        repeat (RD) @(posedge clk);
        @(negedge clk);
        check("slot2 an", 16'(an), 16'(4'b1011));
        check("slot2 seg", 16'(seg), 16'(7'b0000100));

        // Mid-slot-2: flag a bad word, then pulse reset for one cycle.
        load = 1'b1; digits = 16'hF999;
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        check("bad before reset", 16'(bad_digit), 16'(1'b1));
        blank_lz = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midreset an", 16'(an), 16'(4'b1111));
        check("midreset seg", 16'(seg), 16'(7'b1111111));
        check("midreset frame", 16'(frame), 16'(1'b0));
        check("midreset bad", 16'(bad_digit), 16'(1'b0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (RD - 1) @(posedge clk);
        @(negedge clk);
        check("postreset no early tick", 16'(an), 16'(4'b1111));
        @(posedge clk);
        @(negedge clk);
        check("postreset an", 16'(an), 16'(4'b1101));
        check("postreset seg", 16'(seg), 16'(7'b0000001));
        check("postreset frame", 16'(frame), 16'(1'b0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
